// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory bus between the fetch (I) and memory-stage (D) ports.
// The winning request is registered onto the bus; completion is a one-cycle Ready pulse per port.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              IReq,
    input  logic [ADDR_W-1:0] IAddr,
    output logic [DATA_W-1:0] IRData,
    output logic              IReady,
    output logic              IStall,
    input  logic              DReq,
    input  logic              DWrite,
    input  logic [ADDR_W-1:0] DAddr,
    input  logic [DATA_W-1:0] DWData,
    output logic [DATA_W-1:0] DRData,
    output logic              DReady,
    output logic              DStall,
    output logic              BusReq,
    output logic              BusWrite,
    output logic [ADDR_W-1:0] BusAddr,
    output logic [DATA_W-1:0] BusWData,
    input  logic [DATA_W-1:0] BusRData,
    input  logic              BusAck,
    output logic              BusErr
);
    // state  | meaning
    // IDLE   | arbitrate between IReq and DReq
    // I_BUS  | fetch access on the bus, waiting for BusAck or timeout
    // D_BUS  | data access on the bus, waiting for BusAck or timeout
    // RESP   | one-cycle Ready pulse to the granted port
    typedef enum logic [1:0] {IDLE, I_BUS, D_BUS, RESP} state_t;

    localparam int SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX);
    localparam logic [WW-1:0] WAIT_LAST   = WW'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic              breq_q, breq_d;
    logic              bwr_q, bwr_d;
    logic [ADDR_W-1:0] baddr_q, baddr_d;
    logic [DATA_W-1:0] bwdata_q, bwdata_d;
    logic [DATA_W-1:0] irdata_q, irdata_d;
    logic [DATA_W-1:0] drdata_q, drdata_d;
    logic              err_q, err_d;
    logic              gnt_d_q, gnt_d_d;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q  <= IDLE;
            starve_q <= '0;
            wait_q   <= '0;
            breq_q   <= 1'b0;
            bwr_q    <= 1'b0;
            baddr_q  <= '0;
            bwdata_q <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
            err_q    <= 1'b0;
            gnt_d_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            wait_q   <= wait_d;
            breq_q   <= breq_d;
            bwr_q    <= bwr_d;
            baddr_q  <= baddr_d;
            bwdata_q <= bwdata_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
            err_q    <= err_d;
            gnt_d_q  <= gnt_d_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        wait_d   = wait_q;
        breq_d   = breq_q;
        bwr_d    = bwr_q;
        baddr_d  = baddr_q;
        bwdata_d = bwdata_q;
        irdata_d = irdata_q;
        drdata_d = drdata_q;
        err_d    = err_q;
        gnt_d_d  = gnt_d_q;
        case (state_q)
            IDLE: begin
                // D normally wins; a saturated starve count hands the slot to a waiting I.
                if (DReq && !(IReq && starve_q == STARVE_LAST)) begin
                    state_d  = D_BUS;
                    gnt_d_d  = 1'b1;
                    breq_d   = 1'b1;
                    bwr_d    = DWrite;
                    baddr_d  = DAddr;
                    bwdata_d = DWData;
                    wait_d   = '0;
                    if (!IReq) begin
                        starve_d = '0;
                    end else if (starve_q != STARVE_LAST) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else if (IReq) begin
                    state_d  = I_BUS;
                    gnt_d_d  = 1'b0;
                    breq_d   = 1'b1;
                    bwr_d    = 1'b0;
                    baddr_d  = IAddr;
                    bwdata_d = '0;
                    wait_d   = '0;
                    starve_d = '0;
                end
            end
            I_BUS, D_BUS: begin
                wait_d = wait_q + 1'b1;
                if (BusAck) begin
                    breq_d  = 1'b0;
                    state_d = RESP;
                    if (state_q == I_BUS) begin
                        irdata_d = BusRData;
                    end else if (!bwr_q) begin
                        drdata_d = BusRData;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    breq_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign IReady   = (state_q == RESP) && !gnt_d_q;
    assign DReady   = (state_q == RESP) && gnt_d_q;
    assign IStall   = IReq & ~IReady;
    assign DStall   = DReq & ~DReady;
    assign IRData   = irdata_q;
    assign DRData   = drdata_q;
    assign BusReq   = breq_q;
    assign BusWrite = bwr_q;
    assign BusAddr  = baddr_q;
    assign BusWData = bwdata_q;
    assign BusErr   = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction table plus reset, conflict-order sequences.
module tb_mem_port_arbiter;
    logic        CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic        IReq = 1'b0, DReq = 1'b0, DWrite = 1'b0, BusAck = 1'b0;
    logic [31:0] IAddr = '0, DAddr = '0, DWData = '0, BusRData = '0;
    logic [31:0] IRData, DRData, BusAddr, BusWData;
    logic        IReady, IStall, DReady, DStall, BusReq, BusWrite, BusErr;

    int checks = 0;
    int failures = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(8)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .IReq(IReq), .IAddr(IAddr), .IRData(IRData), .IReady(IReady), .IStall(IStall),
        .DReq(DReq), .DWrite(DWrite), .DAddr(DAddr), .DWData(DWData),
        .DRData(DRData), .DReady(DReady), .DStall(DStall),
        .BusReq(BusReq), .BusWrite(BusWrite), .BusAddr(BusAddr), .BusWData(BusWData),
        .BusRData(BusRData), .BusAck(BusAck), .BusErr(BusErr)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        is_d;
        logic        dwrite;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_at;     // BusReq cycle carrying BusAck, 0 = never
        int          exp_lat;    // cycles from request to Ready
        logic        exp_err;
        logic [31:0] exp_rdata;  // requesting port's RData in the Ready cycle
        int          exp_breq;   // number of BusReq cycles
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busreq"},   BusReq,   0);
        chk({tag, "_buswrite"}, BusWrite, 0);
        chk({tag, "_busaddr"},  BusAddr,  0);
        chk({tag, "_buswdata"}, BusWData, 0);
        chk({tag, "_irdata"},   IRData,   0);
        chk({tag, "_drdata"},   DRData,   0);
        chk({tag, "_iready"},   IReady,   0);
        chk({tag, "_dready"},   DReady,   0);
        chk({tag, "_istall"},   IStall,   0);
        chk({tag, "_dstall"},   DStall,   0);
        chk({tag, "_buserr"},   BusErr,   0);
    endtask

    task automatic run_txn(input int idx);
        vec_t        v;
        int          breq_n;
        int          lat;
        logic        ok;
        logic        stable;
        logic        err;
        logic [31:0] rd;
        v = tbl[idx];
        breq_n = 0;
        lat = -1;
        ok = 1'b1;
        stable = 1'b1;
        err = 1'b0;
        rd = '0;
        @(negedge CLK);
        if (v.is_d) begin
            DReq = 1'b1; DWrite = v.dwrite; DAddr = v.addr; DWData = v.wdata;
        end else begin
            IReq = 1'b1; IAddr = v.addr;
        end
        #1;
        if ((v.is_d ? DStall : IStall) !== 1'b1) ok = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge CLK);
            BusAck = 1'b0;
            BusRData = 32'h5A5A_5A5A;
            if (BusReq) begin
                breq_n++;
                if (BusWrite !== (v.is_d & v.dwrite) || BusAddr !== v.addr ||
                    (v.is_d && BusWData !== v.wdata)) stable = 1'b0;
                if (breq_n == v.ack_at) begin
                    BusAck = 1'b1;
                    BusRData = v.rdata;
                end
            end
            #1;
            if (IReady || DReady) begin
                lat = c;
                err = BusErr;
                rd = v.is_d ? DRData : IRData;
                if ((v.is_d ? DReady : IReady) !== 1'b1 || (v.is_d ? IReady : DReady) !== 1'b0 ||
                    (v.is_d ? DStall : IStall) !== 1'b0) ok = 1'b0;
                break;
            end else if ((v.is_d ? DStall : IStall) !== 1'b1 || BusErr !== 1'b0) begin
                ok = 1'b0;
            end
        end
        IReq = 1'b0; DReq = 1'b0; DWrite = 1'b0; BusAck = 1'b0;
        chk($sformatf("v%0d_latency", idx),  lat,    v.exp_lat);
        chk($sformatf("v%0d_buserr", idx),   err,    v.exp_err);
        chk($sformatf("v%0d_rdata", idx),    rd,     v.exp_rdata);
        chk($sformatf("v%0d_breq_cyc", idx), breq_n, v.exp_breq);
        chk($sformatf("v%0d_bus_stable", idx), stable, 1);
        chk($sformatf("v%0d_stall_ready", idx), ok, 1);
    endtask

    initial begin
        int got[10];
        int exp_order[10];
        int n;
        int bad;

        //         is_d  wr    addr       wdata          rdata          ack lat err  exp_rdata     breq
        tbl[0] = '{1'b1, 1'b0, 32'h40,  32'h0000_0000, 32'hDEAD_BEEF, 1, 2, 1'b0, 32'hDEAD_BEEF, 1};
        tbl[1] = '{1'b1, 1'b1, 32'h44,  32'h1234_5678, 32'hBAD0_BAD0, 5, 6, 1'b0, 32'hDEAD_BEEF, 5};
        tbl[2] = '{1'b0, 1'b0, 32'h100, 32'h0000_0000, 32'hCAFE_F00D, 4, 5, 1'b0, 32'hCAFE_F00D, 4};
        tbl[3] = '{1'b0, 1'b0, 32'h104, 32'h0000_0000, 32'h7777_7777, 0, 9, 1'b1, 32'hCAFE_F00D, 8};
        tbl[4] = '{1'b1, 1'b0, 32'h48,  32'h0000_0001, 32'h0BAD_F00D, 8, 9, 1'b0, 32'h0BAD_F00D, 8};
        tbl[5] = '{1'b0, 1'b0, 32'h108, 32'h0000_0000, 32'h1111_2222, 2, 3, 1'b0, 32'h1111_2222, 2};
        tbl[6] = '{1'b1, 1'b0, 32'h4C,  32'h0000_0002, 32'h3333_4444, 0, 9, 1'b1, 32'h0BAD_F00D, 8};
        exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        repeat (3) @(negedge CLK);
        #1;
        check_all_zero("rst0");
        @(negedge CLK);
        RESETn = 1'b1;

        for (int i = 0; i < 7; i++) run_txn(i);

        // Reset in the middle of a D access abandons it.
        @(negedge CLK);
        DReq = 1'b1; DWrite = 1'b0; DAddr = 32'h80;
        repeat (3) @(negedge CLK);
        #1;
        chk("midrst_busreq_before", BusReq, 1);
        @(negedge CLK);
        RESETn = 1'b0;
        DReq = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (2) @(negedge CLK);
        RESETn = 1'b1;
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            BusAck = BusReq;
            #1;
            if (DReady || BusReq) bad++;
        end
        BusAck = 1'b0;
        chk("midrst_no_ready", bad, 0);

        // Both ports request continuously; starvation limit forces every fifth grant to I.
        @(negedge CLK);
        IReq = 1'b1; IAddr = 32'h200;
        DReq = 1'b1; DAddr = 32'h300; DWrite = 1'b0;
        for (int i = 0; i < 10; i++) got[i] = -1;
        n = 0;
        for (int c = 0; c < 400 && n < 10; c++) begin
            @(negedge CLK);
            BusAck = 1'b0;
            if (BusReq) begin
                got[n] = (BusAddr == 32'h200) ? 1 : 0;
                n++;
                BusAck = 1'b1;
            end
        end
        IReq = 1'b0; DReq = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            BusAck = BusReq;
        end
        BusAck = 1'b0;
        for (int i = 0; i < 10; i++) chk($sformatf("grant_%0d_is_i", i), got[i], exp_order[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
